mux4_rr_arbiter: RTL

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_arb_pkg.sv | 19 +
 rtl/mux4_rr_arbiter_rr_pick.sv | 23 ++
 rtl/mux4_rr_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-input round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Round-robin winner selection: first set request after the last winner, with wrap.
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    logic [SEL_W-1:0] v_idx;
    v_idx  = last;
    winner = last;
    any    = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx  = last + SEL_W'(k);
      winner = req[v_idx] ? v_idx : winner;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select, with a bounded hold time per owner.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               gnt_valid,
  output logic               timeout
);

  state_e             r_state;
  logic [SEL_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic               r_valid;
  logic               r_timeout;

  state_e             w_state_nxt;
  logic [SEL_W-1:0]   w_last_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               w_valid_nxt;
  logic               w_timeout_nxt;
  logic [SEL_W-1:0]   w_winner;
  logic               w_any;

  rr_pick u_pick (
    .req    (req),
    .last   (r_last),
    .winner (w_winner),
    .any    (w_any)
  );

  // Next-state and next-output decode; only the owner's request matters while owning.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = OWN;
          w_gnt_nxt   = onehot(w_winner);
          w_sel_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_last_nxt  = w_winner;
          w_cnt_nxt   = '0;
        end else begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end
      OWN: begin
        if (!req[r_sel]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end else if (r_hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // All arbiter state; reset pre-loads last=3 so requester 0 is scanned first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= 2'd3;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_sel      <= 2'd0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_valid    <= w_valid_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule
